// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush scheduler for the 5-stage pipeline
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LoadE,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [1:0]       RS_used_D,
    input  logic             PCSrcE,
    input  logic             MdReqE,
    input  logic             md_done,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             md_start,
    output logic             md_abort,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(MD_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic       md_err_q, md_err_d;

    logic mem_wait;
    logic lu;
    logic hold_mem;
    logic wd_expired;

    // Once in MEM_WAIT the wait lasts until MemReadyM, independent of MemReqM.
    always_comb begin
        mem_wait   = MemReqM & ~MemReadyM;
        lu         = LoadE & (RD_E != 5'd0) &
                     ((RS_used_D[0] & (RD_E == Rs1_D)) |
                      (RS_used_D[1] & (RD_E == Rs2_D)));
        hold_mem   = (state_q == MEM_WAIT) ? ~MemReadyM : mem_wait;
        wd_expired = (wd_q == WD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            wd_q     <= 8'd0;
            md_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            md_err_q <= md_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        md_err_d = md_err_q;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (hold_mem) begin
                    state_d = MEM_WAIT;
                end else if (MdReqE) begin
                    state_d = MD_WAIT;
                    wd_d    = 8'd0;
                end else begin
                    state_d = RUN;
                end
            end
            MD_WAIT: begin
                if (md_done) begin
                    state_d = RUN;
                end else if (wd_expired) begin
                    state_d  = RUN;
                    md_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushM   = 1'b0;
        FlushW   = 1'b0;
        md_start = 1'b0;
        md_abort = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN, MEM_WAIT: begin
                    if (hold_mem) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end else if (MdReqE) begin
                        md_start = 1'b1;
                        StallF   = 1'b1;
                        StallD   = 1'b1;
                        StallE   = 1'b1;
                        FlushM   = 1'b1;
                    end else if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (lu) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (!md_done) begin
                        if (wd_expired) begin
                            md_abort = 1'b1;
                            FlushE   = 1'b1;
                        end else begin
                            StallF = 1'b1;
                            StallD = 1'b1;
                            StallE = 1'b1;
                            FlushM = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign md_err = md_err_q & ~rst;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(StallF);
        flush_count_d  = flush_count_q + CNT_W'(FlushD | FlushE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = rst ? '0 : stall_cycles_q;
    assign flush_count  = rst ? '0 : flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
